// File: rtl/cycle_counter_if.sv
// Count/wrap bundle for consumers of a cycle_counter; the counter drives the
// master side and timestamp or performance logic attaches on the slave side.
interface cycle_counter_if #(
   parameter int unsigned width_p = 32
);
   logic [width_p-1:0] ctr;
   logic               wrap;

   modport master (output ctr, output wrap);
   modport slave  (input  ctr, input  wrap);
endinterface

// File: rtl/cycle_counter.sv
// Free-running modulo-2**width_p cycle counter with a registered one-cycle
// wrap pulse; both outputs come straight from flops.
module cycle_counter #(
   parameter int unsigned     width_p    = 32,
   parameter longint unsigned init_val_p = 0
) (
   input  logic               clk_i,
   input  logic               reset_i,
   output logic [width_p-1:0] ctr_r_o,
   output logic               wrap_r_o
);

   if ((width_p < 1) || (width_p > 64)) begin : g_bad_width
      $error("cycle_counter: width_p must be in 1..64");
   end

   localparam logic [width_p-1:0] InitVal = width_p'(init_val_p);

   logic [width_p-1:0] ctr_q, ctr_d;
   logic               wrap_q, wrap_d;

   // Wrap is registered alongside the rollover, so it is high exactly while
   // the count reads 0 after coming from all-ones.
   always_comb begin
      ctr_d  = ctr_q + width_p'(1);
      wrap_d = &ctr_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ctr_q  <= InitVal;
         wrap_q <= 1'b0;
      end else begin
         ctr_q  <= ctr_d;
         wrap_q <= wrap_d;
      end
   end

   assign ctr_r_o  = ctr_q;
   assign wrap_r_o = wrap_q;

endmodule

// File: tb/tb_cycle_counter.sv
// Directed bench: width sweep 1..8, non-zero init, default width, async reset
// mid-count and reset coincident with a wrap edge.
module tb_cycle_counter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Main width-4 instance, observed through the interface.
   cycle_counter_if #(.width_p(4)) cc_if ();
   cycle_counter #(.width_p(4), .init_val_p(0)) u_dut (
      .clk_i    (clk),
      .reset_i  (rst),
      .ctr_r_o  (cc_if.ctr),
      .wrap_r_o (cc_if.wrap)
   );

   logic [3:0] i10_ctr;
   logic       i10_wrap;
   cycle_counter #(.width_p(4), .init_val_p(10)) u_init10 (
      .clk_i    (clk),
      .reset_i  (rst),
      .ctr_r_o  (i10_ctr),
      .wrap_r_o (i10_wrap)
   );

   logic [31:0] d32_ctr;
   logic        d32_wrap;
   cycle_counter u_default (
      .clk_i    (clk),
      .reset_i  (rst),
      .ctr_r_o  (d32_ctr),
      .wrap_r_o (d32_wrap)
   );

   logic [7:0] sw_ctr  [1:8];
   logic       sw_wrap [1:8];
   for (genvar g = 1; g <= 8; g++) begin : g_sweep
      logic [g-1:0] c;
      cycle_counter #(.width_p(g), .init_val_p(0)) u_sw (
         .clk_i    (clk),
         .reset_i  (rst),
         .ctr_r_o  (c),
         .wrap_r_o (sw_wrap[g])
      );
      assign sw_ctr[g] = 8'(c);
   end

   task automatic chk_reset_state(input string when);
      for (int w = 1; w <= 8; w++) begin
         chk($sformatf("%s w%0d ctr", when, w), 64'(sw_ctr[w]), 64'd0);
         chk($sformatf("%s w%0d wrap", when, w), 64'(sw_wrap[w]), 64'd0);
      end
      chk({when, " if ctr"},  64'(cc_if.ctr), 64'd0);
      chk({when, " if wrap"}, 64'(cc_if.wrap), 64'd0);
      chk({when, " i10 ctr"}, 64'(i10_ctr), 64'd10);
      chk({when, " i10 wrap"}, 64'(i10_wrap), 64'd0);
      chk({when, " d32 ctr"}, 64'(d32_ctr), 64'd0);
      chk({when, " d32 wrap"}, 64'(d32_wrap), 64'd0);
   endtask

   initial begin
      longint unsigned k;
      longint unsigned m;
      longint unsigned e;

      #1 rst = 1'b1;
      #1 chk_reset_state("async-por");
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk_reset_state("held");
      rst = 1'b0;

      // Reference count k = rising edges with reset sampled low.
      for (k = 1; k <= 261; k++) begin
         @(posedge clk);
         #1;
         for (int w = 1; w <= 8; w++) begin
            m = (64'd1 << w) - 64'd1;
            e = k & m;
            chk($sformatf("sweep w%0d k%0d ctr", w, k), 64'(sw_ctr[w]), e);
            chk($sformatf("sweep w%0d k%0d wrap", w, k), 64'(sw_wrap[w]), 64'(e == 0));
         end
         e = (k + 10) % 16;
         chk($sformatf("i10 k%0d ctr", k), 64'(i10_ctr), e);
         chk($sformatf("i10 k%0d wrap", k), 64'(i10_wrap), 64'(e == 0));
         chk($sformatf("d32 k%0d ctr", k), 64'(d32_ctr), k);
         chk($sformatf("d32 k%0d wrap", k), 64'(d32_wrap), 64'd0);
      end

      // 261 mod 16 = 5: assert reset mid-cycle, expect immediate clear.
      chk("pre-async if ctr", 64'(cc_if.ctr), 64'd5);
      #2 rst = 1'b1;
      #1 chk_reset_state("mid-cycle");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post-async if ctr", 64'(cc_if.ctr), 64'd1);
      chk("post-async i10 ctr", 64'(i10_ctr), 64'd11);
      chk("post-async w2 ctr", 64'(sw_ctr[2]), 64'd1);
      chk("post-async w1 ctr", 64'(sw_ctr[1]), 64'd1);
      @(posedge clk);
      #1;
      chk("w2 two", 64'(sw_ctr[2]), 64'd2);
      @(posedge clk);
      #1;
      chk("w2 three", 64'(sw_ctr[2]), 64'd3);
      chk("w2 three wrap", 64'(sw_wrap[2]), 64'd0);

      // Reset arrives on the edge that would roll 3 -> 0; reset must win.
      @(posedge clk);
      rst = 1'b1;
      #1;
      chk("wrap-edge w2 ctr", 64'(sw_ctr[2]), 64'd0);
      chk("wrap-edge w2 wrap", 64'(sw_wrap[2]), 64'd0);
      chk("wrap-edge i10 ctr", 64'(i10_ctr), 64'd10);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("restart w2 ctr", 64'(sw_ctr[2]), 64'd1);
      chk("restart w2 wrap", 64'(sw_wrap[2]), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
